layer_serializer: RTL and testbench

//  Parallel-to-serial converter between network layers. Captures a layer's

---
 rtl/layer_serializer.sv | 76 +++++++
 tb/tb_layer_serializer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/layer_serializer.sv
// layer_serializer: captures a layer's packed output vector on a valid strobe
// and replays it one element per clock as a valid/data stream for the next
// layer's input. A new vector is only taken while idle or on the last element
// of the current stream, which allows gap-free back-to-back streaming.
module layer_serializer #(
  parameter int neurons   = 10,
  parameter int dataWidth = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ser_in_valid,
  input  logic [neurons*dataWidth-1:0]   ser_in_data,
  output logic                           ser_in_ready,
  output logic                           ser_out_valid,
  output logic [dataWidth-1:0]           ser_out_data,
  output logic                           ser_done,
  output logic                           ser_drop
);

  localparam int              IdxW    = $clog2(neurons);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(neurons - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t                         state;
  logic [IdxW-1:0]                idx;
  logic [IdxW-1:0]                next_idx;
  logic [neurons*dataWidth-1:0]   shift_reg;
  logic                           accept;

  // Ready only when no element is still waiting to be emitted after this cycle.
  assign ser_in_ready = (state == IDLE) || ((state == SHIFT) && (idx == LastIdx));
  assign accept       = ser_in_valid & ser_in_ready;

  // Index of the element that will be shown on the next cycle of a running stream.
  always_comb begin
    next_idx = idx + 1'b1;
  end

  // Stream FSM: element 0 is loaded straight from the input on accept, the rest
  // are shifted out of the captured copy, lowest element first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      idx           <= '0;
      shift_reg     <= '0;
      ser_out_valid <= 1'b0;
      ser_out_data  <= '0;
      ser_done      <= 1'b0;
      ser_drop      <= 1'b0;
    end else begin
      ser_drop <= ser_in_valid & ~ser_in_ready;
      if (accept) begin
        state         <= SHIFT;
        idx           <= '0;
        shift_reg     <= ser_in_data >> dataWidth;
        ser_out_valid <= 1'b1;
        ser_out_data  <= ser_in_data[dataWidth-1:0];
        ser_done      <= 1'b0;
      end else if ((state == SHIFT) && (idx != LastIdx)) begin
        idx           <= next_idx;
        shift_reg     <= shift_reg >> dataWidth;
        ser_out_valid <= 1'b1;
        ser_out_data  <= shift_reg[dataWidth-1:0];
        ser_done      <= (next_idx == LastIdx);
      end else begin
        state         <= IDLE;
        idx           <= '0;
        ser_out_valid <= 1'b0;
        ser_out_data  <= '0;
        ser_done      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_layer_serializer.sv
// tb_layer_serializer: cycle table of inputs and expected outputs for a
// 10 x 16-bit layer_serializer, covering reset, single stream, drop during a
// stream, back-to-back vectors, mid-stream reset and continuous valid.
module tb_layer_serializer;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int NumRec = 71;

  logic              clk;
  logic              rst_n;
  logic              ser_in_valid;
  logic [N*DW-1:0]   ser_in_data;
  logic              ser_in_ready;
  logic              ser_out_valid;
  logic [DW-1:0]     ser_out_data;
  logic              ser_done;
  logic              ser_drop;

  int vec_count;
  int miscompares;

  typedef struct {
    logic            rst_n;
    logic            in_valid;
    logic [N*DW-1:0] in_data;
    logic            e_valid;
    logic [DW-1:0]   e_data;
    logic            e_done;
    logic            e_drop;
    logic            e_ready;
  } rec_t;

  rec_t tbl [NumRec];

  layer_serializer #(.neurons(N), .dataWidth(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ser_in_valid  (ser_in_valid),
    .ser_in_data   (ser_in_data),
    .ser_in_ready  (ser_in_ready),
    .ser_out_valid (ser_out_valid),
    .ser_out_data  (ser_out_data),
    .ser_done      (ser_done),
    .ser_drop      (ser_drop)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed vector whose element i holds base+i.
  function automatic logic [N*DW-1:0] mk_vec(input int base);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(base + i);
    return v;
  endfunction

  // Vector presented at cycle a is accepted there and emitted on a+1..a+N.
  task automatic stream(input int a, input int base);
    tbl[a].in_valid = 1'b1;
    tbl[a].in_data  = mk_vec(base);
    for (int k = 0; k < N; k++) begin
      tbl[a+1+k].e_valid = 1'b1;
      tbl[a+1+k].e_data  = DW'(base + k);
      tbl[a+1+k].e_done  = (k == N - 1);
      tbl[a+1+k].e_ready = (k == N - 1);
    end
  endtask

  task automatic check_sig(input string name, input int rec, input logic [DW-1:0] act,
                           input logic [DW-1:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s at record %0d: got %h, expected %h", name, rec, act, exp);
    end
  endtask

  task automatic check_output(input int rec, input logic e_valid, input logic [DW-1:0] e_data,
                              input logic e_done, input logic e_drop, input logic e_ready);
    vec_count++;
    check_sig("ser_out_valid", rec, DW'(ser_out_valid), DW'(e_valid));
    check_sig("ser_out_data",  rec, ser_out_data,       e_data);
    check_sig("ser_done",      rec, DW'(ser_done),      DW'(e_done));
    check_sig("ser_drop",      rec, DW'(ser_drop),      DW'(e_drop));
    check_sig("ser_in_ready",  rec, DW'(ser_in_ready),  DW'(e_ready));
  endtask

  task automatic apply_stimulus(input logic r, input logic v, input logic [N*DW-1:0] d);
    rst_n        = r;
    ser_in_valid = v;
    ser_in_data  = d;
  endtask

  // Main sequence: build the cycle table, reset, then replay the table.
  initial begin
    vec_count   = 0;
    miscompares = 0;

    for (int c = 0; c < NumRec; c++) begin
      tbl[c].rst_n    = 1'b1;
      tbl[c].in_valid = 1'b0;
      tbl[c].in_data  = '0;
      tbl[c].e_valid  = 1'b0;
      tbl[c].e_data   = '0;
      tbl[c].e_done   = 1'b0;
      tbl[c].e_drop   = 1'b0;
      tbl[c].e_ready  = 1'b1;
    end

    // Single vector 1..10, a rejected pulse mid-stream, then B back-to-back.
    stream(0, 16'h0001);
    tbl[5].in_valid = 1'b1;
    tbl[5].in_data  = mk_vec(16'h0050);
    tbl[6].e_drop   = 1'b1;
    stream(10, 16'h0100);

    // Mid-stream reset: stream aborted after element 4, new vector C afterwards.
    stream(22, 16'h0001);
    tbl[26].rst_n = 1'b0;
    stream(27, 16'h0200);
    tbl[27].e_valid = 1'b0;
    tbl[27].e_data  = '0;
    tbl[27].e_done  = 1'b0;
    tbl[27].e_ready = 1'b1;

    // Valid held high with changing data from 39 to 68.
    for (int c = 39; c < 69; c++) begin
      tbl[c].in_valid = 1'b1;
      tbl[c].in_data  = mk_vec(16'h1000 + c * 16);
    end
    stream(39, 16'h1000 + 39 * 16);
    stream(49, 16'h1000 + 49 * 16);
    stream(59, 16'h1000 + 59 * 16);
    for (int c = 41; c <= 69; c++) begin
      if (c != 50 && c != 60) tbl[c].e_drop = 1'b1;
    end

    // Reset held for three edges.
    apply_stimulus(1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    check_output(-1, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    for (int c = 0; c < NumRec; c++) begin
      apply_stimulus(tbl[c].rst_n, tbl[c].in_valid, tbl[c].in_data);
      #1;
      check_output(c, tbl[c].e_valid, tbl[c].e_data, tbl[c].e_done, tbl[c].e_drop,
                   tbl[c].e_ready);
      @(posedge clk);
      #1;
    end

    // Reset with valid high while idle: no drop, nothing accepted.
    apply_stimulus(1'b0, 1'b1, mk_vec(16'h0300));
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 1'b0, '0);
    #1;
    check_output(NumRec, 1'b0, '0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
